// File: rtl/ex_stage_reg.sv
// ex_stage_reg: D->E pipeline stage register with a valid bit, a selectable PC
// policy on flush, and saturating stall/bubble performance counters.
//
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   stall_i       hold all stage registers
//   flush_i       insert a bubble (wins over stall_i)
//   valid_i       incoming instruction is real
//   payload_i     opaque operand/immediate payload from D
//   a3_i, pc_i    destination register number, instruction PC
//   bd_i          branch delay slot flag
//   cnt_clr_i     clear both performance counters
//   valid_o, payload_o, a3_o, pc_o, bd_o   registered stage contents
//   pc4_o         pc_o + 4 (combinational)
//   stall_cnt_o   saturating count of effective stall cycles
//   bubble_cnt_o  saturating count of flush-inserted bubbles
module ex_stage_reg #(
  parameter int              PAYLOAD_W     = 106,
  parameter int              PC_W          = 32,
  parameter logic [PC_W-1:0] RESET_PC      = 32'h0000_3000,
  parameter int              FLUSH_PC_MODE = 1,
  parameter int              CNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic [4:0]           a3_i,
  input  logic [PC_W-1:0]      pc_i,
  input  logic                 bd_i,
  input  logic                 cnt_clr_i,
  output logic                 valid_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [4:0]           a3_o,
  output logic [PC_W-1:0]      pc_o,
  output logic [PC_W-1:0]      pc4_o,
  output logic                 bd_o,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     bubble_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [PC_W-1:0]  PC_FOUR = 4;

  logic                 r_valid;
  logic [PAYLOAD_W-1:0] r_payload;
  logic [4:0]           r_a3;
  logic [PC_W-1:0]      r_pc;
  logic                 r_bd;
  logic [CNT_W-1:0]     r_stall_cnt;
  logic [CNT_W-1:0]     r_bubble_cnt;
  logic [PC_W-1:0]      w_flush_pc;
  logic                 w_stall_eff;

  // PC kept on a bubble so exception logic can still report a location.
  // Unknown modes fall back to zero.
  always_comb begin
    w_flush_pc = '0;
    case (FLUSH_PC_MODE)
      1:       w_flush_pc = pc_i;
      2:       w_flush_pc = r_pc;
      default: w_flush_pc = '0;
    endcase
  end

  assign w_stall_eff = stall_i & ~flush_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
      r_a3      <= '0;
      r_pc      <= RESET_PC;
      r_bd      <= 1'b0;
    end else if (flush_i) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
      r_a3      <= '0;
      r_pc      <= w_flush_pc;
      r_bd      <= bd_i;
    end else if (!stall_i) begin
      r_valid   <= valid_i;
      r_pc      <= pc_i;
      r_bd      <= bd_i;
      // Bubbles carry a zero destination so hazard compares never match them.
      r_payload <= valid_i ? payload_i : '0;
      r_a3      <= valid_i ? a3_i : 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr_i) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall_eff && r_stall_cnt != CNT_MAX)
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (flush_i && r_bubble_cnt != CNT_MAX)
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
    end
  end

  assign valid_o      = r_valid;
  assign payload_o    = r_payload;
  assign a3_o         = r_a3;
  assign pc_o         = r_pc;
  assign pc4_o        = r_pc + PC_FOUR;
  assign bd_o         = r_bd;
  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_ex_stage_reg.sv
// Bench for ex_stage_reg: four instances sharing one stimulus stream, covering
// flush PC modes 1, 2, 0 and an out-of-range mode, plus narrow counters.
module tb_ex_stage_reg;

  localparam int PW = 106;
  localparam int N  = 4;
  localparam int MODE [N] = '{1, 2, 0, 3};
  localparam int CMAX [N] = '{65535, 3, 7, 65535};

  logic          clk = 1'b0;
  logic          reset, stall_i, flush_i, valid_i, bd_i, cnt_clr_i;
  logic [PW-1:0] payload_i;
  logic [4:0]    a3_i;
  logic [31:0]   pc_i;

  logic          o_valid [N];
  logic [PW-1:0] o_pay   [N];
  logic [4:0]    o_a3    [N];
  logic [31:0]   o_pc    [N];
  logic [31:0]   o_pc4   [N];
  logic          o_bd    [N];
  logic [15:0]   o_sc    [N];
  logic [15:0]   o_bc    [N];

  logic [15:0] sc0, bc0, sc3, bc3;
  logic [1:0]  sc1, bc1;
  logic [2:0]  sc2, bc2;

  always #5 clk = ~clk;

  ex_stage_reg #(.FLUSH_PC_MODE(1), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .payload_i(payload_i), .a3_i(a3_i), .pc_i(pc_i), .bd_i(bd_i), .cnt_clr_i(cnt_clr_i),
    .valid_o(o_valid[0]), .payload_o(o_pay[0]), .a3_o(o_a3[0]), .pc_o(o_pc[0]),
    .pc4_o(o_pc4[0]), .bd_o(o_bd[0]), .stall_cnt_o(sc0), .bubble_cnt_o(bc0));
  ex_stage_reg #(.FLUSH_PC_MODE(2), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .payload_i(payload_i), .a3_i(a3_i), .pc_i(pc_i), .bd_i(bd_i), .cnt_clr_i(cnt_clr_i),
    .valid_o(o_valid[1]), .payload_o(o_pay[1]), .a3_o(o_a3[1]), .pc_o(o_pc[1]),
    .pc4_o(o_pc4[1]), .bd_o(o_bd[1]), .stall_cnt_o(sc1), .bubble_cnt_o(bc1));
  ex_stage_reg #(.FLUSH_PC_MODE(0), .CNT_W(3)) u2 (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .payload_i(payload_i), .a3_i(a3_i), .pc_i(pc_i), .bd_i(bd_i), .cnt_clr_i(cnt_clr_i),
    .valid_o(o_valid[2]), .payload_o(o_pay[2]), .a3_o(o_a3[2]), .pc_o(o_pc[2]),
    .pc4_o(o_pc4[2]), .bd_o(o_bd[2]), .stall_cnt_o(sc2), .bubble_cnt_o(bc2));
  ex_stage_reg #(.FLUSH_PC_MODE(3), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .payload_i(payload_i), .a3_i(a3_i), .pc_i(pc_i), .bd_i(bd_i), .cnt_clr_i(cnt_clr_i),
    .valid_o(o_valid[3]), .payload_o(o_pay[3]), .a3_o(o_a3[3]), .pc_o(o_pc[3]),
    .pc4_o(o_pc4[3]), .bd_o(o_bd[3]), .stall_cnt_o(sc3), .bubble_cnt_o(bc3));

  assign o_sc[0] = sc0;            assign o_bc[0] = bc0;
  assign o_sc[1] = {14'd0, sc1};   assign o_bc[1] = {14'd0, bc1};
  assign o_sc[2] = {13'd0, sc2};   assign o_bc[2] = {13'd0, bc2};
  assign o_sc[3] = sc3;            assign o_bc[3] = bc3;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d t=%0t got=%0h expected=%0h", nm, k, $time, act, exp);
  endtask

  // Reference model: what each stage must hold, from the stage's rules.
  logic          m_known = 1'b0;
  logic          m_valid [N];
  logic [PW-1:0] m_pay   [N];
  logic [4:0]    m_a3    [N];
  logic [31:0]   m_pc    [N];
  logic          m_bd    [N];
  int            m_sc    [N];
  int            m_bc    [N];

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        m_valid[k] = 0; m_pay[k] = '0; m_a3[k] = 0; m_pc[k] = 32'h3000; m_bd[k] = 0;
        m_sc[k] = 0; m_bc[k] = 0;
      end else begin
        if (flush_i) begin
          m_valid[k] = 0; m_pay[k] = '0; m_a3[k] = 0; m_bd[k] = bd_i;
          if (MODE[k] == 1)      m_pc[k] = pc_i;
          else if (MODE[k] != 2) m_pc[k] = 0;
        end else if (!stall_i) begin
          m_valid[k] = valid_i; m_pc[k] = pc_i; m_bd[k] = bd_i;
          m_pay[k] = valid_i ? payload_i : '0;
          m_a3[k]  = valid_i ? a3_i : 5'd0;
        end
        if (cnt_clr_i) begin
          m_sc[k] = 0; m_bc[k] = 0;
        end else begin
          if (flush_i && m_bc[k] < CMAX[k]) m_bc[k]++;
          if (stall_i && !flush_i && m_sc[k] < CMAX[k]) m_sc[k]++;
        end
      end
    end
    if (reset) m_known = 1'b1;
  end

  // Compare every cycle once the model is defined.
  always @(negedge clk) begin
    if (m_known) begin
      for (int k = 0; k < N; k++) begin
        chk("valid",   k, 128'(o_valid[k]), 128'(m_valid[k]));
        chk("payload", k, 128'(o_pay[k]),   128'(m_pay[k]));
        chk("a3",      k, 128'(o_a3[k]),    128'(m_a3[k]));
        chk("pc",      k, 128'(o_pc[k]),    128'(m_pc[k]));
        chk("pc4",     k, 128'(o_pc4[k]),   128'(32'(m_pc[k] + 32'd4)));
        chk("bd",      k, 128'(o_bd[k]),    128'(m_bd[k]));
        chk("stall_cnt",  k, 128'(o_sc[k]), 128'(m_sc[k]));
        chk("bubble_cnt", k, 128'(o_bc[k]), 128'(m_bc[k]));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic f, input logic v, input logic [4:0] a3,
                       input logic [31:0] pc, input logic [PW-1:0] pay, input logic bd, input logic clr);
    stall_i = s; flush_i = f; valid_i = v; a3_i = a3; pc_i = pc; payload_i = pay;
    bd_i = bd; cnt_clr_i = clr;
  endtask

  initial begin
    logic [127:0] rnd;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, '0, 0, 0);
    cyc(); cyc();
    reset = 1'b0;
    chk("lit_rst_valid", 0, 128'(o_valid[0]), 128'(0));
    chk("lit_rst_pc",    0, 128'(o_pc[0]),    128'(32'h3000));
    chk("lit_rst_pc4",   0, 128'(o_pc4[0]),   128'(32'h3004));
    chk("lit_rst_a3",    0, 128'(o_a3[0]),    128'(0));
    chk("lit_rst_cnt",   0, 128'({o_sc[0], o_bc[0]}), 128'(0));

    drive(0, 0, 1, 5'd5, 32'h3008, PW'(12'hABC), 0, 0);
    cyc();
    chk("lit_load_valid", 0, 128'(o_valid[0]), 128'(1));
    chk("lit_load_a3",    0, 128'(o_a3[0]),    128'(5));
    chk("lit_load_pc",    0, 128'(o_pc[0]),    128'(32'h3008));
    chk("lit_load_pay",   0, 128'(o_pay[0]),   128'(12'hABC));

    drive(1, 0, 1, 5'd7, 32'h300C, PW'(12'h123), 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("lit_stall_a3", 0, 128'(o_a3[0]), 128'(5));
      chk("lit_stall_pc", 0, 128'(o_pc[0]), 128'(32'h3008));
    end
    chk("lit_stall_cnt", 0, 128'(o_sc[0]), 128'(3));
    stall_i = 1'b0;
    cyc();
    chk("lit_rel_a3", 0, 128'(o_a3[0]), 128'(7));
    chk("lit_rel_pc", 0, 128'(o_pc[0]), 128'(32'h300C));

    drive(0, 1, 1, 5'd9, 32'h3010, PW'(12'h777), 0, 0);
    cyc();
    chk("lit_fl_valid", 0, 128'(o_valid[0]), 128'(0));
    chk("lit_fl_a3",    0, 128'(o_a3[0]),    128'(0));
    chk("lit_fl_pay",   0, 128'(o_pay[0]),   128'(0));
    chk("lit_fl_pc_m1", 0, 128'(o_pc[0]),    128'(32'h3010));
    chk("lit_fl_pc_m2", 1, 128'(o_pc[1]),    128'(32'h300C));
    chk("lit_fl_pc_m0", 2, 128'(o_pc[2]),    128'(0));
    chk("lit_fl_pc_m3", 3, 128'(o_pc[3]),    128'(0));
    chk("lit_fl_bcnt",  0, 128'(o_bc[0]),    128'(1));

    stall_i = 1'b1;
    cyc();
    chk("lit_fs_bcnt", 0, 128'(o_bc[0]), 128'(2));
    chk("lit_fs_scnt", 0, 128'(o_sc[0]), 128'(3));

    drive(0, 0, 1, 5'd3, 32'h3020, PW'(12'h456), 0, 1);
    cyc();
    chk("lit_clr_s", 1, 128'(o_sc[1]), 128'(0));
    cnt_clr_i = 1'b0; stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("lit_sat", 1, 128'(o_sc[1]), 128'((i < 3) ? i + 1 : 3));
    end
    cnt_clr_i = 1'b1;
    cyc();
    chk("lit_sat_clr", 1, 128'(o_sc[1]), 128'(0));
    chk("lit_sat_clr_hold", 1, 128'(o_a3[1]), 128'(3));

    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      reset     = ($urandom_range(0, 79) == 0);
      stall_i   = ($urandom_range(0, 9) < 4);
      flush_i   = ($urandom_range(0, 9) < 2);
      valid_i   = ($urandom_range(0, 9) < 7);
      cnt_clr_i = ($urandom_range(0, 39) == 0);
      bd_i      = $urandom_range(0, 1) == 1;
      a3_i      = 5'($urandom);
      pc_i      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      payload_i = rnd[PW-1:0];
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ex_stage_reg.md
# ex_stage_reg

Parametrised D→E pipeline stage register for the MIPS pipeline core. It supersedes the fixed-field E register and decouples hold (stall) from bubble insertion (flush). It carries a valid bit and a configurable PC policy on flush, so exception logic can still report the PC. It also keeps saturating stall and bubble performance counters that the hazard unit and testbench read out.

## Interface
Parameters:
- PAYLOAD_W, 106 — width of the opaque payload bus (V1, V2, E32, A1, A2 packed by the D stage).
- PC_W, 32 — PC width.
- RESET_PC, 32'h0000_3000 — pc_o value after reset.
- FLUSH_PC_MODE, 1 — PC loaded on flush: 0 = zero, 1 = pc_i, 2 = hold current pc_o.
- CNT_W, 16 — performance counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall_i  in  1  hold: all stage registers keep their value.
- flush_i  in  1  insert bubble.
- valid_i  in  1  incoming instruction is real.
- payload_i  in  PAYLOAD_W  incoming operand/immediate payload.
- a3_i  in  5  incoming destination register number.
- pc_i  in  PC_W  incoming instruction PC.
- bd_i  in  1  incoming instruction sits in a branch delay slot.
- cnt_clr_i  in  1  clear both performance counters.
- valid_o  out  1  stage holds a real instruction.
- payload_o  out  PAYLOAD_W  registered payload.
- a3_o  out  5  registered destination; 0 whenever valid_o = 0.
- pc_o  out  PC_W  registered PC.
- pc4_o  out  PC_W  pc_o + 4, combinational, modulo 2^PC_W.
- bd_o  out  1  registered delay-slot flag.
- stall_cnt_o  out  CNT_W  count of cycles with stall_i taking effect.
- bubble_cnt_o  out  CNT_W  count of bubbles inserted by flush_i.

## Operation
- Priority per edge: reset > flush_i > stall_i > load.
- reset: valid_o=0, payload_o=0, a3_o=0, bd_o=0, pc_o=RESET_PC, both counters=0. pc4_o then reads RESET_PC+4.
- flush_i=1 (stall_i ignored):
  - valid_o=0, payload_o=0, a3_o=0, bd_o=bd_i.
  - pc_o follows FLUSH_PC_MODE: 0 → 0; 1 → pc_i; 2 → unchanged.
- stall_i=1, flush_i=0: every stage register is unchanged.
- Load (neither active):
  - valid_o=valid_i, pc_o=pc_i, bd_o=bd_i.
  - If valid_i=1: payload_o=payload_i, a3_o=a3_i.
  - If valid_i=0: payload_o=0, a3_o=0, so a bubble can never cause a false hazard match.
- stall_cnt_o: +1 on every non-reset edge with stall_i=1 and flush_i=0.
- bubble_cnt_o: +1 on every non-reset edge with flush_i=1.
- Both counters saturate at 2^CNT_W−1 and do not wrap.
- cnt_clr_i=1: both counters go to 0 on that edge. Clear overrides increment. It does not affect the stage registers.
- FLUSH_PC_MODE values other than 0/1/2 behave as 0.

## Timing
- Latency: 1 cycle from inputs to outputs on load or flush.
- Hold lasts exactly as many cycles as stall_i is high; outputs are stable across the whole stall.
- pc4_o is purely combinational from pc_o; there is no other combinational path from input to output.
- Simultaneous flush_i and stall_i: a bubble is inserted and only bubble_cnt_o increments.
- reset asserted in the middle of a stall or flush: the reset values apply on that edge and the counters clear.
- No initial blocks; state is defined only by reset.

## Test plan
- Reset with RESET_PC=0x3000 → valid_o=0, pc_o=0x3000, pc4_o=0x3004, a3_o=0, both counters 0.
- Load valid_i=1, a3_i=5, pc_i=0x3008, payload_i=0xABC → next cycle valid_o=1, a3_o=5, pc_o=0x3008, payload_o=0xABC.
- Load as above, then stall_i=1 for 3 cycles with the inputs changed → outputs unchanged for 3 cycles, stall_cnt_o=3, then the new inputs load.
- flush_i=1 with pc_i=0x3010 in mode 1 → valid_o=0, a3_o=0, payload_o=0, pc_o=0x3010, bubble_cnt_o=1.
  - Repeat in mode 2 → pc_o keeps its prior value.
  - Repeat in mode 0 → pc_o=0.
- flush_i=1 and stall_i=1 together → bubble inserted, bubble_cnt_o=+1, stall_cnt_o unchanged.
- CNT_W=2, hold stall_i high for 5 cycles → stall_cnt_o reads 1, 2, 3, 3, 3. Then cnt_clr_i=1 with stall_i=1 → 0.
